// File: rtl/alu_pkg.sv
// Shared ALU command definitions: opcodes, inputdata field positions and
// the issuer FSM state encoding.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int OP_MSB = 33;
    localparam int A_MSB  = 31;
    localparam int B_MSB  = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_stats.sv
// Wrapping completion counters for the ALU command issuer.
// Built only when ALU_ISSUER_STATS_EN is defined.
`ifdef ALU_ISSUER_STATS_EN
module alu_issue_stats #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hs,
    input  logic             ovf,
    output logic [CNT_W-1:0] ops,
    output logic [CNT_W-1:0] ovfs
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ops  <= '0;
            ovfs <= '0;
        end else if (hs) begin
            ops <= ops + CNT_W'(1);
            if (ovf)
                ovfs <= ovfs + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/alu_cmd_issuer.sv
// Issues one packed command at a time to a fixed-latency ALU and registers
// its result; optional counters enabled by ALU_ISSUER_STATS_EN.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ALU_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [DATA_W-1:0]   cmd_a,
    input  logic [DATA_W-1:0]   cmd_b,
    output logic [2*DATA_W+1:0] inputdata,
    input  logic [DATA_W-1:0]   Y,
    input  logic                cout,
    input  logic                overflow,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_y,
    output logic                rsp_cout,
    output logic                rsp_ovf,
    output logic [CNT_W-1:0]    stat_ops,
    output logic [CNT_W-1:0]    stat_ovf
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(ALU_LAT - 1);

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            inputdata <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        inputdata <= {cmd_op, cmd_a, cmd_b};
                        cnt       <= LAT_M1;
                        cmd_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // cnt==0 marks the edge where the ALU output has settled
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        rsp_y     <= Y;
                        rsp_cout  <= cout;
                        rsp_ovf   <= overflow;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_ISSUER_STATS_EN
    logic hs;
    assign hs = rsp_valid && rsp_ready;

    alu_issue_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk  (clk),
        .rst  (rst),
        .hs   (hs),
        .ovf  (rsp_ovf),
        .ops  (stat_ops),
        .ovfs (stat_ovf)
    );
`else
    assign stat_ops = '0;
    assign stat_ovf = '0;
`endif

endmodule
